alu_wb_stage: RTL and testbench
===============================

// Module: alu_wb_stage
// PURPOSE
//  Writeback stage directly downstream of the 8-bit ALU. Accepts each ALU result
//  (result, cout, z, v, opcode) via valid/ready and buffers it in a small in-order FIFO.
//  Maintains the architectural status register (C/Z/V) and a sticky overflow flag.
//  Presents buffered results to the consumer (register file / output port) via valid/ready.
// PARAMETERS
//  DATA_W  8  ALU result width
//  OPC_W   5  ALU opcode width, stored alongside each result
//  DEPTH   4  FIFO entries; power of two, >= 2
// PORTS
//  clk           in   1       single clock; all state updates on rising edge
//  rst           in   1       synchronous, active-high reset
//  in_valid      in   1       ALU output valid
//  in_ready      out  1       stage can accept (= count < DEPTH)
//  in_result     in   DATA_W  ALU result
//  in_cout       in   1       ALU carry out
//  in_z          in   1       ALU zero flag
//  in_v          in   1       ALU overflow flag
//  in_opcode     in   OPC_W   opcode that produced the result
//  out_valid     out  1       head entry available (= count != 0)
//  out_ready     in   1       consumer takes head entry
//  out_data      out  DATA_W  head entry result
//  out_flags     out  3       head entry {v,z,c}
//  out_opcode    out  OPC_W   head entry opcode
//  out_parity    out  1       head entry even parity (see CONFIGURATION)
//  status_c/z/v  out  1 each  flags of most recently accepted entry
//  sticky_v      out  1       set on any accepted entry with v=1
//  clear_sticky  in   1       clears sticky_v
//  fifo_count    out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (rst=1 at edge): count=0, rd/wr pointers=0, status_c/z/v=0, sticky_v=0;
//    hence in_ready=1, out_valid=0. Reset mid-transfer discards all buffered entries;
//    push/pop asserted during the reset cycle are ignored. Storage array not reset.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready. Both evaluated same edge.
//  - Latency: pushed entry visible on out_* the cycle after push (no combinational bypass).
//  - Full (count=DEPTH): in_ready=0; input held by ALU side unchanged until accepted.
//  - Empty: out_valid=0; out_data/out_flags/out_opcode hold last-read storage (don't care).
//  - Push+pop same cycle (0<count<DEPTH): count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH; count is DEPTH-exact (full and empty distinguishable).
//  - out_* are driven from storage[rd_ptr]; stable while out_valid=1 & out_ready=0.
//  - Status register: on push, {status_v,status_z,status_c} <= {in_v,in_z,in_cout}; else hold.
//  - sticky_v: next = (sticky_v & ~clear_sticky) | (push & in_v); set wins over clear.
//  - No state machine beyond FIFO pointer/count bookkeeping; no arithmetic on data.
// CONFIGURATION
//  ALU_WB_PARITY_EN defined: per-entry even parity (^in_result) computed on push, stored
//    with entry, driven on out_parity with head entry.
//  Not defined: no parity storage; out_parity tied 0.
// STRUCTURE
//  Package alu_pkg: DATA_W, OPC_W constants; FLAG_C=0, FLAG_Z=1, FLAG_V=2 indices;
//    typedef alu_wb_entry_t {result, flags[2:0], opcode, parity}.
//  Sub-module alu_wb_fifo: generic sync FIFO of alu_wb_entry_t (DEPTH, count, pointers);
//    alu_wb_stage adds status/sticky logic and parity generation around it.
// TESTING
//  1 Reset: rst=1 two cycles -> in_ready=1, out_valid=0, fifo_count=0, status/sticky=0.
//  2 Single pass: push result=0x49,cout=1,z=0,v=0,opcode=0 -> next cycle out_valid=1,
//    out_data=0x49, out_flags=3'b001; status_c=1; out_ready=1 -> fifo_count=0.
//  3 Fill: out_ready=0, push 0x01..0x04 -> in_ready=0 after 4th, 5th held; drain gives
//    0x01,0x02,0x03,0x04 in order; pointers wrap on further 4 pushes, order kept.
//  4 Simultaneous: count=2, push 0x80 and pop same cycle -> count stays 2, 0x80 at tail.
//  5 Sticky: push v=1 then v=0 -> status_v=0, sticky_v=1; clear_sticky with push v=1
//    same cycle -> sticky_v=1; clear_sticky alone -> 0.
//  6 Reset mid-op: 3 entries held, rst=1 with in_valid=1 -> count=0, out_valid=0; with
//    ALU_WB_PARITY_EN push 0x07 -> out_parity=1, push 0x03 -> out_parity=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU writeback stage.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 5;

  // Bit positions within the 3-bit flags field {v,z,c}
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [2:0]        flags;
    logic [OPC_W-1:0]  opcode;
    logic              parity;
  } alu_wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// In-order synchronous FIFO of alu_wb_entry_t.
// The count is exact, so a full FIFO and an empty FIFO can be told apart.
// Reads come straight from storage[rd_ptr], so there is no bypass path.
// The storage array itself is never reset.
module alu_wb_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  alu_wb_entry_t wr_entry,
  output alu_wb_entry_t rd_entry,
  output logic          full,
  output logic          empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  alu_wb_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
  assign rd_entry = mem[rd_ptr];

  // Entry storage. A write is ignored during the reset cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage.
// Buffers ALU results in the FIFO, and keeps the C/Z/V status register and the sticky
// overflow flag.
// Optional feature macro: ALU_WB_PARITY_EN. When it is defined, each entry stores its
// even parity, which is driven on out_parity.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_cout,
  input  logic                     in_z,
  input  logic                     in_v,
  input  logic [OPC_W-1:0]         in_opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [2:0]               out_flags,
  output logic [OPC_W-1:0]         out_opcode,
  output logic                     out_parity,
  output logic                     status_c,
  output logic                     status_z,
  output logic                     status_v,
  output logic                     sticky_v,
  input  logic                     clear_sticky,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  alu_wb_entry_t wr_entry;
  alu_wb_entry_t rd_entry;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pack the incoming ALU result into a FIFO entry.
  always_comb begin
    wr_entry                = '0;
    wr_entry.result         = in_result;
    wr_entry.flags[FLAG_C]  = in_cout;
    wr_entry.flags[FLAG_Z]  = in_z;
    wr_entry.flags[FLAG_V]  = in_v;
    wr_entry.opcode         = in_opcode;
`ifdef ALU_WB_PARITY_EN
    wr_entry.parity         = ^in_result;
`else
    wr_entry.parity         = 1'b0;
`endif
  end

  alu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  assign out_data   = rd_entry.result;
  assign out_flags  = rd_entry.flags;
  assign out_opcode = rd_entry.opcode;

`ifdef ALU_WB_PARITY_EN
  assign out_parity = rd_entry.parity;
`else
  logic unused_parity;
  assign unused_parity = rd_entry.parity;
  assign out_parity    = 1'b0;
`endif

  // Status register follows the most recently accepted entry.
  // The sticky set from a push takes priority over clear_sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_c <= 1'b0;
      status_z <= 1'b0;
      status_v <= 1'b0;
      sticky_v <= 1'b0;
    end else begin
      if (push) begin
        status_c <= in_cout;
        status_z <= in_z;
        status_v <= in_v;
      end
      sticky_v <= (sticky_v & ~clear_sticky) | (push & in_v);
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios followed by random traffic.
// All outputs are checked against a queue-based reference model.
module tb_alu_wb_stage;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic       in_cout;
  logic       in_z;
  logic       in_v;
  logic [4:0] in_opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_flags;
  logic [4:0] out_opcode;
  logic       out_parity;
  logic       status_c;
  logic       status_z;
  logic       status_v;
  logic       sticky_v;
  logic       clear_sticky;
  logic [2:0] fifo_count;

  alu_wb_stage #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_cout      (in_cout),
    .in_z         (in_z),
    .in_v         (in_v),
    .in_opcode    (in_opcode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .out_opcode   (out_opcode),
    .out_parity   (out_parity),
    .status_c     (status_c),
    .status_z     (status_z),
    .status_v     (status_v),
    .sticky_v     (sticky_v),
    .clear_sticky (clear_sticky),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] f;
    logic [4:0] o;
  } m_entry_t;

  m_entry_t q[$];
  logic     m_c, m_z, m_v, m_sticky;
  int       vectors    = 0;
  int       miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_parity(input logic [7:0] d);
`ifdef ALU_WB_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  // Compare every DUT output with the model.
  task automatic check_all();
    chk("count",     32'(fifo_count), 32'(q.size()));
    chk("in_ready",  32'(in_ready),   32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid),  32'(q.size() != 0));
    chk("status_c",  32'(status_c),   32'(m_c));
    chk("status_z",  32'(status_z),   32'(m_z));
    chk("status_v",  32'(status_v),   32'(m_v));
    chk("sticky_v",  32'(sticky_v),   32'(m_sticky));
    if (q.size() != 0) begin
      chk("out_data",   32'(out_data),   32'(q[0].d));
      chk("out_flags",  32'(out_flags),  32'(q[0].f));
      chk("out_opcode", 32'(out_opcode), 32'(q[0].o));
      chk("out_parity", 32'(out_parity), 32'(exp_parity(q[0].d)));
    end
  endtask

  // Advance one clock, update the model from the inputs applied before the edge, then check.
  task automatic cycle();
    bit       acc, take;
    m_entry_t e;
    acc    = in_valid && (q.size() < DEPTH);
    take   = out_ready && (q.size() != 0);
    e.d    = in_result;
    e.f    = {in_v, in_z, in_cout};
    e.o    = in_opcode;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_c = 0; m_z = 0; m_v = 0; m_sticky = 0;
    end else begin
      m_sticky = (m_sticky && !clear_sticky) || (acc && e.f[2]);
      if (take) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        m_c = e.f[0]; m_z = e.f[1]; m_v = e.f[2];
      end
    end
    check_all();
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic z,
                       input logic ov, input logic [4:0] op, input logic rdy, input logic clr);
    in_valid = v; in_result = d; in_cout = c; in_z = z; in_v = ov; in_opcode = op;
    out_ready = rdy; clear_sticky = clr;
  endtask

  logic [7:0] exp_d;

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 5'd0, 0, 0);
    // Reset held for two cycles.
    cycle();
    cycle();
    chk("t1_in_ready",  32'(in_ready),   32'd1);
    chk("t1_out_valid", 32'(out_valid),  32'd0);
    chk("t1_count",     32'(fifo_count), 32'd0);
    chk("t1_sticky",    32'(sticky_v),   32'd0);
    rst = 1'b0;

    // Single pass.
    drive(1, 8'h49, 1, 0, 0, 5'd0, 0, 0);
    cycle();
    drive(0, 8'h00, 0, 0, 0, 5'd0, 0, 0);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_data",  32'(out_data),  32'h49);
    chk("t2_out_flags", 32'(out_flags), 32'b001);
    chk("t2_status_c",  32'(status_c),  32'd1);
    out_ready = 1'b1;
    cycle();
    chk("t2_count", 32'(fifo_count), 32'd0);

    // Fill to full, hold a fifth entry, drain, then repeat across the pointer wrap.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 1; i <= 4; i++) begin
        drive(1, 8'(i + 4 * pass), 0, 0, 0, 5'(i), 0, 0);
        cycle();
      end
      chk("t3_full_ready", 32'(in_ready),   32'd0);
      chk("t3_full_count", 32'(fifo_count), 32'd4);
      drive(1, 8'h55, 0, 1, 0, 5'd9, 0, 0);
      cycle();
      cycle();
      chk("t3_held_count", 32'(fifo_count), 32'd4);
      chk("t3_held_head",  32'(out_data),   32'(8'(1 + 4 * pass)));
      drive(0, 8'h00, 0, 0, 0, 5'd0, 1, 0);
      for (int i = 1; i <= 4; i++) begin
        exp_d = 8'(i + 4 * pass);
        chk("t3_drain_order", 32'(out_data), 32'(exp_d));
        cycle();
      end
      chk("t3_drained", 32'(out_valid), 32'd0);
    end

    // Simultaneous push and pop at count 2.
    drive(1, 8'h11, 0, 0, 0, 5'd1, 0, 0); cycle();
    drive(1, 8'h22, 0, 0, 0, 5'd2, 0, 0); cycle();
    drive(1, 8'h80, 1, 0, 1, 5'd3, 1, 0); cycle();
    chk("t4_count", 32'(fifo_count), 32'd2);
    chk("t4_head",  32'(out_data),   32'h22);
    drive(0, 8'h00, 0, 0, 0, 5'd0, 1, 0); cycle();
    chk("t4_tail",  32'(out_data),   32'h80);
    cycle();
    drive(0, 8'h00, 0, 0, 0, 5'd0, 0, 1); cycle();

    // Sticky overflow: set wins over clear, and a lone clear drops it.
    drive(1, 8'h7f, 0, 0, 1, 5'd4, 1, 0); cycle();
    drive(1, 8'h01, 0, 0, 0, 5'd4, 1, 0); cycle();
    chk("t5_status_v", 32'(status_v), 32'd0);
    chk("t5_sticky",   32'(sticky_v), 32'd1);
    drive(1, 8'h02, 0, 0, 1, 5'd4, 1, 1); cycle();
    chk("t5_set_wins", 32'(sticky_v), 32'd1);
    drive(0, 8'h00, 0, 0, 0, 5'd0, 1, 1); cycle();
    chk("t5_cleared",  32'(sticky_v), 32'd0);
    drive(0, 8'h00, 0, 0, 0, 5'd0, 1, 0); cycle();

    // Reset mid-operation with a push requested.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'hA0 + i), 1, 1, 1, 5'd7, 0, 0); cycle();
    end
    chk("t6_three", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    drive(1, 8'hEE, 1, 0, 1, 5'd8, 1, 0);
    cycle();
    rst = 1'b0;
    chk("t6_count",     32'(fifo_count), 32'd0);
    chk("t6_out_valid", 32'(out_valid),  32'd0);
    chk("t6_sticky",    32'(sticky_v),   32'd0);
    drive(1, 8'h07, 0, 0, 0, 5'd1, 0, 0); cycle();
    drive(0, 8'h00, 0, 0, 0, 5'd0, 1, 0);
`ifdef ALU_WB_PARITY_EN
    chk("t6_parity_07", 32'(out_parity), 32'd1);
`else
    chk("t6_parity_off", 32'(out_parity), 32'd0);
`endif
    cycle();
    drive(1, 8'h03, 0, 0, 0, 5'd1, 0, 0); cycle();
    drive(0, 8'h00, 0, 0, 0, 5'd0, 1, 0);
    chk("t6_parity_03", 32'(out_parity), 32'd0);
    cycle();

    // Random traffic; a stalled input is held stable until it is accepted.
    for (int n = 0; n < 400; n++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_result = 8'($urandom);
        in_cout   = 1'($urandom);
        in_z      = 1'($urandom);
        in_v      = ($urandom_range(0, 7) == 0);
        in_opcode = 5'($urandom);
      end
      out_ready    = ($urandom_range(0, 2) == 0);
      clear_sticky = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
